adcv_sample_averager: RTL and testbench



---
 rtl/adcv_pkg.sv | 16 +
 rtl/adcv_sync_fifo.sv | 62 ++++++
 rtl/adcv_sample_averager.sv | 160 ++++++++++++++++
 tb/tb_adcv_sample_averager.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adcv_pkg.sv
// Shared constants, types and helpers for the ADC sample averager.
package adcv_pkg;

  localparam int ADCV_SAMPLE_BITS = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } adcv_state_t;

  // Accumulator width for 2^avg_log2 samples of in_bits each; cannot overflow.
  function automatic int sum_width(input int in_bits, input int avg_log2);
    return in_bits + avg_log2;
  endfunction

endpackage

// File: rtl/adcv_sync_fifo.sv
// Small first-word-fall-through FIFO: head is visible on pop_data while !empty.
// Latency: push visible one edge later; a push while full succeeds only alongside a pop.
module adcv_sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adcv_sample_averager.sv
// Block averager: means of 2^AVG_LOG2 ADC samples queued in an FWFT FIFO; ADCV_MINMAX_EN adds per-block min/max.
// Latency: 2 edges from the last sample of a block to avg_valid (FIFO empty).
// Backpressure: avg_valid/avg_ready pop; a mean arriving at a full FIFO with no pop is dropped and counted.
module adcv_sample_averager
  import adcv_pkg::*;
#(
  parameter int IN_BITS    = ADCV_SAMPLE_BITS,
  parameter int AVG_LOG2   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_BITS  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [IN_BITS-1:0]   sample_in,
  input  logic                 sample_valid,
  output logic [IN_BITS-1:0]   avg_data,
  output logic                 avg_valid,
  input  logic                 avg_ready,
  output logic [DROP_BITS-1:0] drop_count,
  output logic                 busy
`ifdef ADCV_MINMAX_EN
  ,
  output logic [IN_BITS-1:0]   avg_min,
  output logic [IN_BITS-1:0]   avg_max
`endif
);

  localparam int SUM_W = sum_width(IN_BITS, AVG_LOG2);
`ifdef ADCV_MINMAX_EN
  localparam int ENTRY_W = 3 * IN_BITS;
`else
  localparam int ENTRY_W = IN_BITS;
`endif

  localparam logic [AVG_LOG2-1:0]  CNT_ONE  = AVG_LOG2'(1);
  localparam logic [AVG_LOG2-1:0]  CNT_LAST = '1;
  localparam logic [DROP_BITS-1:0] DROP_ONE = DROP_BITS'(1);

  adcv_state_t         state;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2-1:0] cnt;
  logic                push_req;
  logic [IN_BITS-1:0]  push_data;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  assign sum_next = sum + {{AVG_LOG2{1'b0}}, sample_in};

`ifdef ADCV_MINMAX_EN
  logic [IN_BITS-1:0] blk_min;
  logic [IN_BITS-1:0] blk_max;
  logic [IN_BITS-1:0] min_next;
  logic [IN_BITS-1:0] max_next;
  logic [IN_BITS-1:0] push_min;
  logic [IN_BITS-1:0] push_max;

  // The first sample of a block seeds both extremes.
  always_comb begin
    min_next = sample_in;
    max_next = sample_in;
    if (cnt != '0) begin
      min_next = (sample_in < blk_min) ? sample_in : blk_min;
      max_next = (sample_in > blk_max) ? sample_in : blk_max;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      blk_min  <= '0;
      blk_max  <= '0;
      push_min <= '0;
      push_max <= '0;
    end else if (state == ACCUM && enable && sample_valid) begin
      blk_min <= min_next;
      blk_max <= max_next;
      if (cnt == CNT_LAST) begin
        push_min <= min_next;
        push_max <= max_next;
      end
    end
  end

  assign push_entry = {push_max, push_min, push_data};
  assign avg_data   = head_entry[IN_BITS-1:0];
  assign avg_min    = head_entry[2*IN_BITS-1:IN_BITS];
  assign avg_max    = head_entry[3*IN_BITS-1:2*IN_BITS];
`else
  assign push_entry = push_data;
  assign avg_data   = head_entry;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      sum       <= '0;
      cnt       <= '0;
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (!enable) begin
            // Abandon the partial block without emitting anything.
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
          end else if (sample_valid) begin
            if (cnt == CNT_LAST) begin
              push_req  <= 1'b1;
              push_data <= sum_next[SUM_W-1:AVG_LOG2];
              sum       <= '0;
              cnt       <= '0;
            end else begin
              sum <= sum_next;
              cnt <= cnt + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  assign busy      = (state == ACCUM) && (cnt != '0);
  assign avg_valid = !fifo_empty;
  assign pop       = avg_valid && avg_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_count <= '0;
    end else if (push_req && fifo_full && !pop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_ONE;
    end
  end

  adcv_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_adcv_sample_averager.sv
// Directed bench for adcv_sample_averager: one instance with 4-sample blocks, one with 16-sample blocks.
module tb_adcv_sample_averager;

  logic       clock = 1'b0;
  logic       reset;
  logic       en2, vld2, rdy2;
  logic [6:0] smp2;
  logic [6:0] data2;
  logic       valid2, busy2;
  logic [15:0] drop2;
  logic       en4, vld4, rdy4;
  logic [6:0] smp4;
  logic [6:0] data4;
  logic       valid4, busy4;
  logic [15:0] drop4;
`ifdef ADCV_MINMAX_EN
  logic [6:0] min2, max2, min4, max4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  adcv_sample_averager #(
    .IN_BITS(7), .AVG_LOG2(2), .FIFO_DEPTH(4), .DROP_BITS(16)
  ) dut2 (
    .clock        (clock),
    .reset        (reset),
    .enable       (en2),
    .sample_in    (smp2),
    .sample_valid (vld2),
    .avg_data     (data2),
    .avg_valid    (valid2),
    .avg_ready    (rdy2),
    .drop_count   (drop2),
    .busy         (busy2)
`ifdef ADCV_MINMAX_EN
    ,
    .avg_min      (min2),
    .avg_max      (max2)
`endif
  );

  adcv_sample_averager #(
    .IN_BITS(7), .AVG_LOG2(4), .FIFO_DEPTH(4), .DROP_BITS(16)
  ) dut4 (
    .clock        (clock),
    .reset        (reset),
    .enable       (en4),
    .sample_in    (smp4),
    .sample_valid (vld4),
    .avg_data     (data4),
    .avg_valid    (valid4),
    .avg_ready    (rdy4),
    .drop_count   (drop4),
    .busy         (busy4)
`ifdef ADCV_MINMAX_EN
    ,
    .avg_min      (min4),
    .avg_max      (max4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic feed_one(input int v);
    smp2 = 7'(v);
    vld2 = 1'b1;
    tick();
    vld2 = 1'b0;
  endtask

  task automatic feed_block(input int a, input int b, input int c, input int d);
    feed_one(a);
    feed_one(b);
    feed_one(c);
    feed_one(d);
  endtask

  initial begin
    reset = 1'b1;
    en2 = 1'b0; vld2 = 1'b0; rdy2 = 1'b0; smp2 = '0;
    en4 = 1'b0; vld4 = 1'b0; rdy4 = 1'b0; smp4 = '0;
    tick();
    tick();
    chk("rst_valid", 32'(valid2), 0);
    chk("rst_data", 32'(data2), 0);
    chk("rst_drop", 32'(drop2), 0);
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_valid4", 32'(valid4), 0);

    // Basic mean and 2-edge latency: 10,11,12,13 -> 46>>2 = 11.
    reset = 1'b0;
    en2 = 1'b1;
    rdy2 = 1'b1;
    tick();
    feed_one(10);
    chk("busy_mid", 32'(busy2), 1);
    feed_one(11);
    feed_one(12);
    feed_one(13);
    chk("lat_edge_n", 32'(valid2), 0);
    chk("busy_wrap", 32'(busy2), 0);
    tick();
    chk("lat_valid", 32'(valid2), 1);
    chk("mean_11", 32'(data2), 11);
    tick();
    chk("one_cycle", 32'(valid2), 0);

    // Invalid cycles stall: 8,8,8,12 with gaps -> 9.
    feed_one(8);
    tick();
    feed_one(8);
    tick();
    tick();
    feed_one(8);
    feed_one(12);
    chk("stall_pend", 32'(valid2), 0);
    tick();
    chk("stall_valid", 32'(valid2), 1);
    chk("stall_mean", 32'(data2), 9);
    tick();
    chk("stall_empty", 32'(valid2), 0);

    // Six blocks into a 4-deep FIFO with no reader: means 4k+1.
    rdy2 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      feed_block(4*k, 4*k+1, 4*k+2, 4*k+3);
    end
    tick();
    chk("bp_drop", 32'(drop2), 2);
    chk("bp_valid", 32'(valid2), 1);
    chk("bp_head0", 32'(data2), 5);
    rdy2 = 1'b1;
    tick();
    chk("bp_head1", 32'(data2), 9);
    tick();
    chk("bp_head2", 32'(data2), 13);
    tick();
    chk("bp_head3", 32'(data2), 17);
    tick();
    chk("bp_drained", 32'(valid2), 0);

    // Push into a full FIFO on the same edge as a pop.
    rdy2 = 1'b0;
    feed_block(40, 40, 40, 40);
    feed_block(41, 41, 41, 41);
    feed_block(42, 42, 42, 42);
    feed_block(43, 43, 43, 43);
    feed_block(44, 44, 44, 44);
    rdy2 = 1'b1;
    tick();
    rdy2 = 1'b0;
    chk("swap_drop", 32'(drop2), 2);
    chk("swap_head", 32'(data2), 41);
    feed_block(45, 45, 45, 45);
    tick();
    chk("swap_full", 32'(drop2), 3);
    rdy2 = 1'b1;
    tick();
    chk("swap_q1", 32'(data2), 42);
    tick();
    chk("swap_q2", 32'(data2), 43);
    tick();
    chk("swap_q3", 32'(data2), 44);
    tick();
    chk("swap_empty", 32'(valid2), 0);

    // Disabling mid-block discards the partial sum.
    rdy2 = 1'b0;
    feed_one(9);
    feed_one(9);
    feed_one(9);
    chk("abort_busy", 32'(busy2), 1);
    en2 = 1'b0;
    tick();
    chk("abort_idle", 32'(busy2), 0);
    chk("abort_nopush", 32'(valid2), 0);
    en2 = 1'b1;
    tick();
    feed_block(4, 4, 4, 4);
    tick();
    chk("abort_valid", 32'(valid2), 1);
    chk("abort_mean", 32'(data2), 4);
    rdy2 = 1'b1;
    tick();
    tick();
    chk("abort_only1", 32'(valid2), 0);
    rdy2 = 1'b0;

`ifdef ADCV_MINMAX_EN
    feed_block(5, 100, 7, 20);
    tick();
    chk("mm_mean", 32'(data2), 33);
    chk("mm_min", 32'(min2), 5);
    chk("mm_max", 32'(max2), 100);
    feed_block(6, 6, 6, 6);
    tick();
    rdy2 = 1'b1;
    tick();
    chk("mm_eq_mean", 32'(data2), 6);
    chk("mm_eq_min", 32'(min2), 6);
    chk("mm_eq_max", 32'(max2), 6);
    tick();
    chk("mm_empty", 32'(valid2), 0);
    rdy2 = 1'b0;
`endif

    // Reset with a queued entry, a partial block and a nonzero drop count.
    feed_block(7, 7, 7, 7);
    tick();
    feed_one(1);
    feed_one(1);
    chk("pre_rst_busy", 32'(busy2), 1);
    chk("pre_rst_valid", 32'(valid2), 1);
    chk("pre_rst_drop", 32'(drop2), 3);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(valid2), 0);
    chk("mid_rst_data", 32'(data2), 0);
    chk("mid_rst_drop", 32'(drop2), 0);
    chk("mid_rst_busy", 32'(busy2), 0);
    reset = 1'b0;

    // 16-sample blocks: all 127 then all 0, back to back.
    en4 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      smp4 = 7'd127;
      vld4 = 1'b1;
      tick();
      if (i == 7) chk("b16_busy", 32'(busy4), 1);
    end
    for (int i = 0; i < 16; i++) begin
      smp4 = 7'd0;
      vld4 = 1'b1;
      tick();
    end
    vld4 = 1'b0;
    tick();
    chk("b16_valid", 32'(valid4), 1);
    chk("b16_max", 32'(data4), 127);
    rdy4 = 1'b1;
    tick();
    chk("b16_zero_v", 32'(valid4), 1);
    chk("b16_zero", 32'(data4), 0);
    tick();
    chk("b16_empty", 32'(valid4), 0);
    chk("b16_drop", 32'(drop4), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
